set_bit_serializer: RTL and testbench

SET_BIT_SERIALIZER -- requirements
Module: set_bit_serializer

---
 rtl/set_bit_ser_pkg.sv | 23 ++
 rtl/lowest_set_bit_enc.sv | 38 +++
 rtl/set_bit_serializer.sv | 109 ++++++++++
 tb/tb_set_bit_serializer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/set_bit_ser_pkg.sv
// ----------------------------------------------------------------------------
// set_bit_ser_pkg
// Shared definitions for the set-bit serializer:
//   - state_e     : two-state FSM encoding (IDLE = 0, EMIT = 1)
//   - idx_width() : width of a binary bit index for a WIDTH-bit vector
//   - cnt_width() : width of a counter able to hold 0..WIDTH
// ----------------------------------------------------------------------------
package set_bit_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic int idx_width(input int width);
        return $clog2(width);
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/lowest_set_bit_enc.sv
// ----------------------------------------------------------------------------
// lowest_set_bit_enc
// Purely combinational: isolates the lowest set bit of the remaining vector.
// Ports:
//   rem_i    [WIDTH-1:0] remaining (not yet emitted) set bits
//   onehot_o [WIDTH-1:0] lowest set bit of rem_i, one-hot (0 when rem_i == 0)
//   idx_o    [IDX_W-1:0] binary position of onehot_o (0 when rem_i == 0)
//   last_o               no set bit remains above onehot_o (also 1 when empty)
// ----------------------------------------------------------------------------
module lowest_set_bit_enc
    import set_bit_ser_pkg::*;
#(
    parameter  int WIDTH = 12,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] rem_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);

    // Two's-complement trick: rem & -rem keeps only the lowest set bit.
    assign onehot_o = rem_i & (~rem_i + WIDTH'(1));

    assign last_o = ((rem_i & ~onehot_o) == '0);

    // onehot_o has at most one bit set, so OR-ing the matching index is exact.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot_o[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/set_bit_serializer.sv
// ----------------------------------------------------------------------------
// set_bit_serializer
// Accepts a WIDTH-bit request vector and emits one beat per set bit, lowest
// bit first. An all-zero vector yields a single empty beat.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   in_valid_i / in_ready_o    vector handshake (ready only in IDLE)
//   vec_i       [WIDTH-1:0]    vector to serialize
//   out_valid_o / out_ready_i  beat handshake
//   onehot_o    [WIDTH-1:0]    current bit, one-hot
//   idx_o       [IDX_W-1:0]    binary index of onehot_o
//   seq_o       [CNT_W-1:0]    beat number within the vector, from 0
//   last_o                     final beat of the vector
//   empty_o                    the vector was all-zero
// Data outputs are forced to 0 while idle.
// ----------------------------------------------------------------------------
module set_bit_serializer
    import set_bit_ser_pkg::*;
#(
    parameter  int WIDTH = 12,
    localparam int IDX_W = idx_width(WIDTH),
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] vec_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [CNT_W-1:0] seq_o,
    output logic             last_o,
    output logic             empty_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic [CNT_W-1:0] seq_q,   seq_d;
    logic             empty_q, empty_d;

    logic [WIDTH-1:0] enc_onehot;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_last;
    logic             emitting;

    lowest_set_bit_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .rem_i    (rem_q),
        .onehot_o (enc_onehot),
        .idx_o    (enc_idx),
        .last_o   (enc_last)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        seq_d   = seq_q;
        empty_d = empty_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    rem_d   = vec_i;
                    seq_d   = '0;
                    empty_d = (vec_i == '0);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                // Vectors offered here are ignored; only a beat transfer moves us.
                if (out_ready_i) begin
                    rem_d = rem_q & ~enc_onehot;
                    if (enc_last) begin
                        state_d = IDLE;
                    end else begin
                        seq_d = seq_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            seq_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
            empty_q <= empty_d;
        end
    end

    assign emitting    = (state_q == EMIT);
    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = emitting;
    assign onehot_o    = emitting ? enc_onehot : '0;
    assign idx_o       = emitting ? enc_idx    : '0;
    assign seq_o       = emitting ? seq_q      : '0;
    assign last_o      = emitting & enc_last;
    assign empty_o     = emitting & empty_q;

endmodule

// File: tb/tb_set_bit_serializer.sv
// ----------------------------------------------------------------------------
// tb_set_bit_serializer
// Directed test of set_bit_serializer at WIDTH = 12. Inputs change and outputs
// are sampled on the falling edge, half a period away from the active edge.
// ----------------------------------------------------------------------------
module tb_set_bit_serializer;

    localparam int WIDTH = 12;
    localparam int IDX_W = 4;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] vec_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] onehot_o;
    logic [IDX_W-1:0] idx_o;
    logic [CNT_W-1:0] seq_o;
    logic             last_o;
    logic             empty_o;

    int tests  = 0;
    int failed = 0;

    set_bit_serializer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .vec_i       (vec_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .onehot_o    (onehot_o),
        .idx_o       (idx_o),
        .seq_o       (seq_o),
        .last_o      (last_o),
        .empty_o     (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid_o), 64'd0);
        check({tag, ".in_ready"},  64'(in_ready_o),  64'd1);
        check({tag, ".onehot"},    64'(onehot_o),    64'd0);
        check({tag, ".idx"},       64'(idx_o),       64'd0);
        check({tag, ".seq"},       64'(seq_o),       64'd0);
        check({tag, ".last"},      64'(last_o),      64'd0);
        check({tag, ".empty"},     64'(empty_o),     64'd0);
    endtask

    // Offer a vector in IDLE for one cycle; EMIT is entered on the next edge.
    task automatic send(input logic [WIDTH-1:0] v);
        check("send.in_ready", 64'(in_ready_o), 64'd1);
        in_valid_i = 1'b1;
        vec_i      = v;
        tick();
        in_valid_i = 1'b0;
        vec_i      = '0;
    endtask

    task automatic check_beat(input string tag, input logic [WIDTH-1:0] oh, input int idx,
                              input int seq, input logic last, input logic empty);
        check({tag, ".out_valid"}, 64'(out_valid_o), 64'd1);
        check({tag, ".in_ready"},  64'(in_ready_o),  64'd0);
        check({tag, ".onehot"},    64'(onehot_o),    64'(oh));
        check({tag, ".idx"},       64'(idx_o),       64'(idx));
        check({tag, ".seq"},       64'(seq_o),       64'(seq));
        check({tag, ".last"},      64'(last_o),      64'(last));
        check({tag, ".empty"},     64'(empty_o),     64'(empty));
    endtask

    // Check a beat and take it.
    task automatic beat(input string tag, input logic [WIDTH-1:0] oh, input int idx,
                        input int seq, input logic last, input logic empty);
        check_beat(tag, oh, idx, seq, last, empty);
        out_ready_i = 1'b1;
        tick();
    endtask

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        vec_i       = '0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        tick();
        rst_i = 1'b0;
        check_idle("reset");

        // 0x824: bits 2, 5, 11.
        send(12'h824);
        beat("v824.b0", 12'h004, 2,  0, 1'b0, 1'b0);
        beat("v824.b1", 12'h020, 5,  1, 1'b0, 1'b0);
        beat("v824.b2", 12'h800, 11, 2, 1'b1, 1'b0);
        check_idle("v824.done");

        // Zero vector: a single empty beat.
        send(12'h000);
        beat("v000.b0", 12'h000, 0, 0, 1'b1, 1'b1);
        check_idle("v000.done");

        // All ones: twelve back-to-back beats.
        send(12'hFFF);
        for (int i = 0; i < WIDTH; i++) begin
            logic [WIDTH-1:0] oh;
            oh = '0;
            oh[i] = 1'b1;
            beat($sformatf("vFFF.b%0d", i), oh, i, i, (i == WIDTH - 1), 1'b0);
        end
        check_idle("vFFF.done");

        // 0x0A0 with back-pressure on the first beat and a competing vector
        // offered during EMIT that must not be captured.
        send(12'h0A0);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        vec_i       = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("v0A0.hold%0d", i), 12'h020, 5, 0, 1'b0, 1'b0);
            tick();
        end
        in_valid_i = 1'b0;
        vec_i      = '0;
        beat("v0A0.b0", 12'h020, 5, 0, 1'b0, 1'b0);
        beat("v0A0.b1", 12'h080, 7, 1, 1'b1, 1'b0);
        check_idle("v0A0.done");
        tick();
        check_idle("v0A0.nocapture");

        // Reset in the middle of 0xFFF, at the 4th beat.
        send(12'hFFF);
        beat("rst.b0", 12'h001, 0, 0, 1'b0, 1'b0);
        beat("rst.b1", 12'h002, 1, 1, 1'b0, 1'b0);
        beat("rst.b2", 12'h004, 2, 2, 1'b0, 1'b0);
        check_beat("rst.b3", 12'h008, 3, 3, 1'b0, 1'b0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_idle("rst.after");
        send(12'h001);
        beat("v001.b0", 12'h001, 0, 0, 1'b1, 1'b0);
        check_idle("v001.done");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
